// File: rtl/chk_pkg.sv
// Shared types and helpers for the sequence checker.
package chk_pkg;

  // Run-control states of the checker.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  // Wide enough for the largest supported start-to-compare latency (15).
  localparam int LAT_W = 4;

  // Index width helper: a one-bit index still needs one bit of storage.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with a zero flag; it stops at zero rather than wrapping.
module down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load has priority over decrement; the count holds once it reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_checker.sv
// Response checker: after a start pulse and a fixed latency, compares one
// sample per clock against PATTERN (bit 0 first) and reports the mismatch
// count, the first failing index and a pass/fail verdict.
//
// Handshake: start is a single-cycle request. It is accepted only when the
// checker is not busy (IDLE or DONE); a start seen while busy is dropped,
// never queued. The results are valid while done is high and are held until
// the next accepted start clears them.
module seq_checker
  import chk_pkg::*;
#(
  parameter int             LEN     = 8,
  parameter logic [LEN-1:0] PATTERN = 8'b0110_1001,
  parameter int             LATENCY = 1,
  parameter int             CNT_W   = $clog2(LEN + 1),
  parameter int             IDX_W   = clog2_min1(LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [IDX_W-1:0] cur_idx,
  output chk_state_t       state_dbg
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  chk_state_t       state, state_n;
  logic [CNT_W-1:0] err_n;
  logic             fev_n;
  logic [IDX_W-1:0] fei_n;
  logic [IDX_W-1:0] idx_n;
  logic             cnt_load;
  logic             cnt_en;
  logic [LAT_W-1:0] wait_count;
  logic             wait_zero;
  logic             mismatch;

  // Counts out the pipeline latency between an accepted start and the first compare.
  down_counter #(
    .W(LAT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (LAT_W'(LATENCY)),
    .en       (cnt_en),
    .count    (wait_count),
    .zero     (wait_zero)
  );

  // Case inequality so an unknown sample is scored as a mismatch in simulation.
  assign mismatch = (sample_in !== PATTERN[cur_idx]);

  // Next-state and next-result logic for the run controller.
  always_comb begin
    state_n  = state;
    err_n    = err_count;
    fev_n    = first_err_valid;
    fei_n    = first_err_idx;
    idx_n    = cur_idx;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          err_n    = '0;
          fev_n    = 1'b0;
          fei_n    = '0;
          idx_n    = '0;
          cnt_load = 1'b1;
          state_n  = (LATENCY == 0) ? CHECK : WAIT;
        end
      end
      WAIT: begin
        cnt_en = 1'b1;
        // The zero test only guards against a stuck WAIT; normal exit is at one.
        if ((wait_count == LAT_W'(1)) || wait_zero) begin
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_n = err_count + CNT_W'(1);
          if (!first_err_valid) begin
            fev_n = 1'b1;
            fei_n = cur_idx;
          end
        end
        if (cur_idx == LAST_IDX) begin
          idx_n   = '0;
          state_n = DONE;
        end else begin
          idx_n = cur_idx + IDX_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, results and status flags; status is derived from the next state so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      cur_idx         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else begin
      state           <= state_n;
      err_count       <= err_n;
      first_err_valid <= fev_n;
      first_err_idx   <= fei_n;
      cur_idx         <= idx_n;
      busy            <= (state_n == WAIT) || (state_n == CHECK);
      done            <= (state_n == DONE);
      pass            <= (state_n == DONE) && (err_n == '0);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_seq_checker.sv
// Bench for seq_checker: two instances (latency 1 and latency 0) share the
// stimulus; a per-run reference model derives each instance's expected
// results and done edge from the planned sample stream.
module tb_seq_checker;
  import chk_pkg::*;

  localparam int             LEN = 8;
  localparam logic [LEN-1:0] PAT = 8'b0110_1001;
  localparam int             W   = 9;  // {pass, first_valid, first_idx[2:0], err[3:0]}

  logic clk;
  logic rst_n;
  logic start;
  logic sample_in;

  logic       busy1, done1, pass1, fev1;
  logic [3:0] err1;
  logic [2:0] fei1, idx1;
  chk_state_t st1;
  logic       busy0, done0, pass0, fev0;
  logic [3:0] err0;
  logic [2:0] fei0, idx0;
  chk_state_t st0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp0_q[$];
  int           cyc1_q[$];
  int           cyc0_q[$];

  seq_checker #(.LEN(LEN), .PATTERN(PAT), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_in(sample_in),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fev1), .first_err_idx(fei1), .cur_idx(idx1),
    .state_dbg(st1)
  );

  seq_checker #(.LEN(LEN), .PATTERN(PAT), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_in(sample_in),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_valid(fev0), .first_err_idx(fei0), .cur_idx(idx0),
    .state_dbg(st0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: with latency lat, index i is compared against the sample
  // present at edge start+lat+1+i; X counts as a mismatch.
  function automatic logic [W-1:0] model(input int lat, input logic s[16]);
    int          errs  = 0;
    int          first = -1;
    logic [7:0]  p     = PAT;
    logic [2:0]  fi;
    for (int i = 0; i < LEN; i++) begin
      if (s[lat + 1 + i] !== p[i]) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    fi = (first >= 0) ? 3'(first) : 3'd0;
    return {(errs == 0), (first >= 0), fi, 4'(errs)};
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start     = 1'b0;
      sample_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  // One run: mode shapes the latency-1 sample window; gap is edges until the
  // next run may start; mid_k >= 1 pulses start again while busy.
  task automatic run(input int mode, input int gap, input int mid_k);
    logic       s[16];
    logic [7:0] p = PAT;
    logic       flip;
    int         e0;
    int         xi;
    xi = $urandom_range(0, LEN - 1);
    for (int k = 0; k < 16; k++) s[k] = 1'($urandom_range(0, 1));
    for (int i = 0; i < LEN; i++) begin
      case (mode)
        0:       flip = 1'b0;
        1:       flip = (i == 3);
        2:       flip = 1'b1;
        3:       flip = ($urandom_range(0, 3) == 0);
        default: flip = 1'($urandom_range(0, 1));
      endcase
      s[i + 2] = p[i] ^ flip;
      if (mode == 5 && i == xi) s[i + 2] = 1'bx;
    end
    e0 = cyc + 1;
    exp1_q.push_back(model(1, s));
    cyc1_q.push_back(e0 + 1 + LEN);
    exp0_q.push_back(model(0, s));
    cyc0_q.push_back(e0 + LEN);
    for (int k = 0; k < gap; k++) begin
      start     = (k == 0) || (k == mid_k);
      sample_in = s[k];
      @(posedge clk);
      #1;
      if (k == 0) begin
        check("busy_after_start_l1", 32'(busy1), 32'd1);
        check("busy_after_start_l0", 32'(busy0), 32'd1);
        check("cleared_on_start_l1", {done1, fev1, err1}, 32'd0);
        check("cleared_on_start_l0", {done0, fev0, err0}, 32'd0);
      end
    end
    start = 1'b0;
  endtask

  // ---------------- scoreboard monitors ----------------
  logic         d1_prev = 1'b0;
  logic         d0_prev = 1'b0;
  logic [W-1:0] m1_e, m0_e;
  int           m1_c, m0_c;

  // Latency-1 instance: score results and done edge when done rises.
  always @(negedge clk) begin
    if (!rst_n) begin
      d1_prev = 1'b0;
    end else begin
      if (done1 && !d1_prev) begin
        if (exp1_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL l1_unexpected_done: got done=1 expected no run at cycle %0d", cyc);
        end else begin
          m1_e = exp1_q.pop_front();
          m1_c = cyc1_q.pop_front();
          check("l1_result", 32'({pass1, fev1, fei1, err1}), 32'(m1_e));
          check("l1_done_edge", cyc, m1_c);
        end
      end
      d1_prev = done1;
    end
  end

  // Latency-0 instance: same scoring with its own expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      d0_prev = 1'b0;
    end else begin
      if (done0 && !d0_prev) begin
        if (exp0_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL l0_unexpected_done: got done=1 expected no run at cycle %0d", cyc);
        end else begin
          m0_e = exp0_q.pop_front();
          m0_c = cyc0_q.pop_front();
          check("l0_result", 32'({pass0, fev0, fei0, err0}), 32'(m0_e));
          check("l0_done_edge", cyc, m0_c);
        end
      end
      d0_prev = done0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] p = PAT;
    int         waited;
    rst_n     = 1'b0;
    start     = 1'b0;
    sample_in = 1'b0;
    #12;
    check("reset_flags_l1", {busy1, done1, pass1, fev1}, 32'd0);
    check("reset_values_l1", {err1, fei1, idx1}, 32'd0);
    check("reset_state_l1", 32'(st1), 32'(IDLE));
    check("reset_flags_l0", {busy0, done0, pass0, fev0}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(3);

    // Directed: exact, single error at 3, inverted, start while busy.
    run(0, 10, -1);
    run(1, 10, -1);
    run(2, 10, -1);
    run(0, 11, 6);
    run(5, 10, -1);

    // Reset during CHECK after two logged errors on the latency-1 instance.
    start     = 1'b1;
    sample_in = 1'b0;
    @(posedge clk);
    #1;
    start     = 1'b0;
    sample_in = ~p[0];
    @(posedge clk);
    #1;
    sample_in = ~p[0];
    @(posedge clk);
    #1;
    sample_in = ~p[1];
    @(posedge clk);
    #1;
    check("pre_reset_errs_l1", 32'(err1), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_reset_busy_done", {busy1, done1, busy0, done0}, 32'd0);
    check("mid_reset_results_l1", {err1, fev1, fei1, idx1}, 32'd0);
    check("mid_reset_results_l0", {err0, fev0, fei0, idx0}, 32'd0);
    exp1_q.delete();
    exp0_q.delete();
    cyc1_q.delete();
    cyc0_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);
    check("post_reset_state_l1", 32'(st1), 32'(IDLE));
    check("post_reset_state_l0", 32'(st0), 32'(IDLE));
    run(0, 10, -1);

    // Randomized runs, mostly back-to-back.
    for (int r = 0; r < 24; r++) begin
      run($urandom_range(0, 5), $urandom_range(10, 13),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1);
    end

    // Let the last run retire, bounded.
    waited = 0;
    while ((exp1_q.size() != 0 || exp0_q.size() != 0) && waited < 40) begin
      idle_cycles(1);
      waited++;
    end
    check("drain_l1", exp1_q.size(), 32'd0);
    check("drain_l0", exp0_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Response-side counterpart to a stimulus driver: samples a DUT output once per clock and compares it against a parameterised expected bit sequence.
- Reports the mismatch count, the first failing index and a pass/fail verdict.
- Sits in benches beside clk_gen and the DUT; fully synthesizable, so it can also serve as an on-chip self-check.

Parameters:
- LEN, 8, number of bits in the expected sequence (1..256).
- PATTERN, 8'b0110_1001, expected sequence, LEN bits wide; bit 0 is checked first.
- LATENCY, 1, cycles between the start pulse and the first compare (covers DUT pipeline delay); range 0..15.
- CNT_W, $clog2(LEN+1), width of the error counter.
- IDX_W, $clog2(LEN) (minimum 1), width of the index outputs.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a check run.
- sample_in  input  1  DUT output under check.
- busy  output  1  high in WAIT and CHECK.
- done  output  1  high in DONE; held until the next accepted start.
- pass  output  1  valid while done; 1 iff err_count == 0.
- err_count  output  CNT_W  number of mismatches in the current/last run.
- first_err_valid  output  1  a mismatch has been recorded in this run.
- first_err_idx  output  IDX_W  sequence index of the first mismatch.
- cur_idx  output  IDX_W  index being compared (debug); 0 outside CHECK.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - busy, done, pass, first_err_valid = 0.
  - err_count, first_err_idx, cur_idx = 0.
  - Takes effect immediately, including mid-run; no partial results are retained.
- States: IDLE, WAIT, CHECK, DONE.
- IDLE:
  - start=1 → clear err_count, first_err_valid and first_err_idx.
  - Load the wait counter with LATENCY.
  - Go to WAIT, or directly to CHECK when LATENCY=0.
- WAIT:
  - Decrement the wait counter each cycle.
  - Move to CHECK on the edge where the counter is 1.
  - sample_in is ignored.
- CHECK:
  - On each rising edge, compare sample_in against PATTERN[cur_idx].
  - Mismatch → err_count += 1. If first_err_valid=0, also set first_err_idx = cur_idx and first_err_valid = 1.
  - cur_idx increments each cycle; on the edge with cur_idx == LEN-1, go to DONE and reset cur_idx to 0.
  - Exactly LEN compares are made.
- Compare timing:
  - With LATENCY=L and start sampled high at edge E0, the first compare happens at edge E0+L+1.
  - For L=0, the first compare is at edge E0+1.
- DONE:
  - done=1 and pass=(err_count==0); all results are held.
  - start=1 → behave as the IDLE start, so back-to-back runs need no idle cycle.
- start while busy (WAIT or CHECK) is ignored; it does not restart and is not queued.
- err_count cannot overflow: CNT_W holds LEN, so no saturation logic is needed.
- X on sample_in during CHECK counts as a mismatch; use a case-inequality compare under simulation.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package chk_pkg:
  - chk_state_t enum {IDLE, WAIT, CHECK, DONE}.
  - A localparam helper function clog2_min1 for the index widths.
- One sub-module is natural: down_counter (load, en, width param, zero flag), used for the WAIT phase.
- Everything else stays in seq_checker.

Test Plan:
- Exact match: PATTERN=8'b0110_1001, LATENCY=1. After start, drive 1,0,0,1,0,1,1,0 starting at the second edge → done at edge 9; pass=1; err_count=0; first_err_valid=0.
- Single error: same setup, flip the bit at index 3 → err_count=1; first_err_idx=3; pass=0.
- Multiple errors: drive inverted sequence → err_count=8; first_err_idx=0.
- Start while busy: pulse start at index 4 of CHECK → run unaffected; done still at edge 9.
- Back-to-back run:
  - Assert start in the cycle done rises → new run begins.
  - Previous results are cleared on the same edge.
  - busy=1 on the next cycle.
- Reset mid-run: drop rst_n during CHECK with 2 errors logged → immediately busy=0, done=0, err_count=0; after release, state is IDLE and the next run is clean.
- LATENCY=0 variant: first compare on the edge after start; total run length 8 edges.
